// File: rtl/tlc_phase_scheduler_if.sv
// Request inputs and light/status outputs of the intersection phase scheduler.
// The master side drives the requests; the scheduler is the slave.
interface tlc_phase_scheduler_if;
    logic       ped_req;
    logic       emerg;
    logic [0:2] ns_light;
    logic [0:2] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output ped_req, emerg,
        input  ns_light, ew_light, walk, ped_ack, phase
    );

    modport slave (
        input  ped_req, emerg,
        output ns_light, ew_light, walk, ped_ack, phase
    );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Two-approach traffic light phase scheduler with pedestrian walk insertion
// and emergency all-red hold. All outputs are registered.
module tlc_phase_scheduler #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 3,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned WALK_CYC   = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    tlc_phase_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        StNsG   = 3'd0,
        StNsY   = 3'd1,
        StAr1   = 3'd2,
        StEwG   = 3'd3,
        StEwY   = 3'd4,
        StAr2   = 3'd5,
        StWalk  = 3'd6,
        StEmerg = 3'd7
    } state_e;

    localparam logic [0:2] Red    = 3'b100;
    localparam logic [0:2] Green  = 3'b010;
    localparam logic [0:2] Yellow = 3'b001;

    state_e     state_q, state_d;
    state_e     rec_q, rec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic [0:2] ns_q, ns_d;
    logic [0:2] ew_q, ew_d;
    logic       walk_q, walk_d;
    logic       ack_q, ack_d;
    logic       expired;
    logic       entering_walk;

    function automatic logic [7:0] dur_m1(state_e s);
        logic [7:0] d;
        case (s)
            StNsG, StEwG: d = 8'(GREEN_CYC - 1);
            StNsY, StEwY: d = 8'(YELLOW_CYC - 1);
            StAr1, StAr2: d = 8'(ALLRED_CYC - 1);
            StWalk:       d = 8'(WALK_CYC - 1);
            default:      d = 8'd0;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        expired   = (cnt_q == 8'd0);
        cnt_d     = expired ? cnt_q : cnt_q - 8'd1;
        pending_d = pending_q | (bus.ped_req && (state_q != StWalk));

        // Emergency beats timer expiry, which beats pedestrian diversion.
        unique case (state_q)
            StNsG:   if (bus.emerg || expired) state_d = StNsY;
            StEwG:   if (bus.emerg || expired) state_d = StEwY;
            StNsY:   if (expired) state_d = bus.emerg ? StEmerg : StAr1;
            StEwY:   if (expired) state_d = bus.emerg ? StEmerg : StAr2;
            StAr1: begin
                if (bus.emerg) begin
                    state_d = StEmerg;
                end else if (expired) begin
                    if (pending_q) begin
                        state_d = StWalk;
                        rec_d   = StEwG;
                    end else begin
                        state_d = StEwG;
                    end
                end
            end
            StAr2: begin
                if (bus.emerg) begin
                    state_d = StEmerg;
                end else if (expired) begin
                    if (pending_q) begin
                        state_d = StWalk;
                        rec_d   = StNsG;
                    end else begin
                        state_d = StNsG;
                    end
                end
            end
            StWalk: begin
                if (bus.emerg) begin
                    state_d = StEmerg;
                end else if (expired) begin
                    state_d = rec_q;
                end
            end
            StEmerg: if (!bus.emerg) state_d = StAr2;
        endcase

        if (state_d != state_q) begin
            cnt_d = dur_m1(state_d);
        end

        entering_walk = (state_d == StWalk) && (state_q != StWalk);
        if (entering_walk) begin
            pending_d = 1'b0;
        end

        ns_d   = Red;
        ew_d   = Red;
        walk_d = 1'b0;
        ack_d  = entering_walk;
        unique case (state_d)
            StNsG:  ns_d = Green;
            StNsY:  ns_d = Yellow;
            StEwG:  ew_d = Green;
            StEwY:  ew_d = Yellow;
            StWalk: walk_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StAr2;
            rec_q     <= StNsG;
            cnt_q     <= 8'(ALLRED_CYC - 1);
            pending_q <= 1'b0;
            ns_q      <= Red;
            ew_q      <= Red;
            walk_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ns_q      <= ns_d;
            ew_q      <= ew_d;
            walk_q    <= walk_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.ns_light = ns_q;
    assign bus.ew_light = ew_q;
    assign bus.walk     = walk_q;
    assign bus.ped_ack  = ack_q;
    assign bus.phase    = state_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: directed scenarios plus random
// request/emergency traffic against a phase-level behavioural model.
module tb_tlc_phase_scheduler;

    localparam int GREEN  = 8;
    localparam int YELLOW = 3;
    localparam int ALLRED = 2;
    localparam int WALKD  = 5;

    logic clk;
    logic rst_n;

    tlc_phase_scheduler_if bus ();

    tlc_phase_scheduler #(
        .GREEN_CYC  (GREEN),
        .YELLOW_CYC (YELLOW),
        .ALLRED_CYC (ALLRED),
        .WALK_CYC   (WALKD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase code, cycles left in this phase, pending request, recorded green.
    int m_phase;
    int m_left;
    bit m_pend;
    int m_rec;
    bit m_ack;

    // Light value (as 3-bit number) per phase code: RED=4, GREEN=2, YELLOW=1.
    int ns_tab [8] = '{2, 1, 4, 4, 4, 4, 4, 4};
    int ew_tab [8] = '{4, 4, 4, 2, 1, 4, 4, 4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input int p);
        if (p == 0 || p == 3) return GREEN;
        if (p == 1 || p == 4) return YELLOW;
        if (p == 2 || p == 5) return ALLRED;
        if (p == 6) return WALKD;
        return 1;
    endfunction

    task automatic model_reset();
        m_phase = 5;
        m_left  = ALLRED;
        m_pend  = 0;
        m_rec   = 0;
        m_ack   = 0;
    endtask

    task automatic model_step(input bit req, input bit em);
        int  np;
        bit  done;
        done = (m_left == 1);
        np   = m_phase;
        case (m_phase)
            0, 3: if (em || done) np = m_phase + 1;
            1, 4: if (done) np = em ? 7 : m_phase + 1;
            2, 5: begin
                if (em) np = 7;
                else if (done) begin
                    if (m_pend) begin
                        m_rec = (m_phase == 2) ? 3 : 0;
                        np    = 6;
                    end else begin
                        np = (m_phase == 2) ? 3 : 0;
                    end
                end
            end
            6: if (em) np = 7; else if (done) np = m_rec;
            default: if (!em) np = 5;
        endcase
        if (m_phase != 6 && req) m_pend = 1;
        m_ack = (np == 6 && m_phase != 6);
        if (m_ack) m_pend = 0;
        if (np != m_phase) m_left = dur_of(np);
        else if (m_left > 1) m_left--;
        m_phase = np;
    endtask

    task automatic compare_all();
        check_eq("phase",   32'(bus.phase),    32'(m_phase));
        check_eq("ns",      32'(bus.ns_light), 32'(ns_tab[m_phase]));
        check_eq("ew",      32'(bus.ew_light), 32'(ew_tab[m_phase]));
        check_eq("walk",    32'(bus.walk),     32'(m_phase == 6));
        check_eq("ped_ack", 32'(bus.ped_ack),  32'(m_ack));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(bus.ped_req, bus.emerg);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int code, input int max_cyc);
        int k;
        k = 0;
        while (m_phase != code && k < max_cyc) begin
            step();
            k++;
        end
        check_eq("wait_timeout", 32'(m_phase), 32'(code));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ns"},    32'(bus.ns_light), 32'd4);
        check_eq({tag, "_ew"},    32'(bus.ew_light), 32'd4);
        check_eq({tag, "_walk"},  32'(bus.walk),     32'd0);
        check_eq({tag, "_ack"},   32'(bus.ped_ack),  32'd0);
        check_eq({tag, "_phase"}, 32'(bus.phase),    32'd5);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain cycling: NS_G entered on 2nd edge, then two full 26-cycle periods.
        step();
        check_eq("still_ar2", 32'(bus.phase), 32'd5);
        step();
        check_eq("first_nsg", 32'(bus.phase), 32'd0);
        run(52);

        // One-cycle ped pulse during NS_G.
        wait_phase(0, 40);
        step();
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_phase(6, 40);
        check_eq("walk_ack_first", 32'(bus.ped_ack), 32'd1);
        run(WALKD);
        check_eq("after_walk_ewg", 32'(bus.phase), 32'd3);

        // Request held across a whole WALK and past its expiry.
        bus.ped_req = 1'b1;
        wait_phase(6, 60);
        run(WALKD + 2);
        bus.ped_req = 1'b0;
        run(40);

        // Emergency at 3rd cycle of EW_G.
        wait_phase(3, 80);
        run(2);
        bus.emerg = 1'b1;
        step();
        check_eq("emerg_ew_yellow", 32'(bus.ew_light), 32'd1);
        run(YELLOW + 6);
        bus.emerg = 1'b0;
        run(ALLRED + 4);

        // Emergency during WALK, new request latched while in EMERG.
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        wait_phase(6, 60);
        step();
        bus.emerg = 1'b1;
        step();
        check_eq("walk_cut", 32'(bus.walk), 32'd0);
        bus.ped_req = 1'b1;
        step();
        bus.ped_req = 1'b0;
        run(3);
        bus.emerg = 1'b0;
        run(ALLRED + 2);
        run(20);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.ped_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) bus.emerg = ~bus.emerg;
            step();
        end
        bus.ped_req = 1'b0;
        bus.emerg   = 1'b0;
        run(30);

        // Asynchronous reset mid EW_Y, between edges.
        wait_phase(4, 80);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
